alu_arbiter: RTL and testbench

Shares one combinational 32-bit MIPS ALU between two requesters (e.g. the integer pipe and the address/branch unit). It arbitrates round-robin and registers the winning operation onto the ALU input bus. One cycle later it captures the ALU result and flags, then returns them on a single tagged response channel with valid/ready backpressure. Opcodes outside the ALU's supported set get a flagged, zeroed response instead of being issued.

---
 rtl/alu_arbiter.sv | 171 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational MIPS ALU between two requesters.
// Winning operation is registered onto the ALU bus, the result is captured one
// cycle later and returned on a tagged valid/ready response channel.
module alu_arbiter #(
  parameter int unsigned OP_W   = 11,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  // requester 0
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_in0,
  input  logic [DATA_W-1:0] req0_in1,
  // requester 1
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_in0,
  input  logic [DATA_W-1:0] req1_in1,
  // response channel
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_out,
  output logic              resp_overflow,
  output logic              resp_zero,
  output logic              resp_carryout,
  output logic              resp_illegal,
  // shared ALU
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_in0,
  output logic [DATA_W-1:0] alu_in1,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_overflow,
  input  logic              alu_zero,
  input  logic              alu_carryout,
  // statistics
  output logic [CNT_W-1:0]  ops_done
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e              state_q, state_d;
  logic                last_q;
  logic                id_q;
  logic                illegal_q;
  logic [OP_W-1:0]     alu_op_q;
  logic [DATA_W-1:0]   alu_in0_q, alu_in1_q;
  logic                resp_id_q, resp_ovf_q, resp_zero_q, resp_cout_q, resp_ill_q;
  logic [DATA_W-1:0]   resp_out_q;
  logic [CNT_W-1:0]    ops_done_q;

  logic                grant0, grant1, accept, win_id, win_legal;
  logic [OP_W-1:0]     win_op;
  logic [DATA_W-1:0]   win_in0, win_in1;

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    logic legal;
    case (op)
      OP_W'('h20), OP_W'('h21), OP_W'('h22), OP_W'('h23),
      OP_W'('h24), OP_W'('h25), OP_W'('h26), OP_W'('h27),
      OP_W'('h2A), OP_W'('h2B), OP_W'('h00), OP_W'('h02),
      OP_W'('h03), OP_W'('h04), OP_W'('h06), OP_W'('h07): legal = 1'b1;
      default:                                           legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Round-robin grant: on a tie the requester that did not win last time goes.
  // Ready is masked during reset so all outputs read 0 while rst is held.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_q);
    grant1     = req1_valid && (!req0_valid || !last_q);
    req0_ready = !rst && (state_q == StIdle) && grant0;
    req1_ready = !rst && (state_q == StIdle) && grant1;
    accept     = req0_ready || req1_ready;
    win_id     = req1_ready;
    win_op     = win_id ? req1_op  : req0_op;
    win_in0    = win_id ? req1_in0 : req0_in0;
    win_in1    = win_id ? req1_in1 : req0_in1;
    win_legal  = is_legal(win_op);
  end

  // Next-state logic: IDLE -> EXEC on accept, EXEC -> RESP always, RESP -> IDLE on take.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, arbitration pointer and per-operation tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      id_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_q    <= win_id;
        id_q      <= win_id;
        illegal_q <= !win_legal;
      end
    end
  end

  // ALU input bus: loaded only for a legal accepted op, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op_q  <= '0;
      alu_in0_q <= '0;
      alu_in1_q <= '0;
    end else if (accept && win_legal) begin
      alu_op_q  <= win_op;
      alu_in0_q <= win_in0;
      alu_in1_q <= win_in1;
    end
  end

  // Capture the settled ALU result at the end of EXEC; illegal ops return zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_id_q   <= 1'b0;
      resp_out_q  <= '0;
      resp_ovf_q  <= 1'b0;
      resp_zero_q <= 1'b0;
      resp_cout_q <= 1'b0;
      resp_ill_q  <= 1'b0;
    end else if (state_q == StExec) begin
      resp_id_q   <= id_q;
      resp_ill_q  <= illegal_q;
      resp_out_q  <= illegal_q ? '0 : alu_out;
      resp_ovf_q  <= !illegal_q && alu_overflow;
      resp_zero_q <= !illegal_q && alu_zero;
      resp_cout_q <= !illegal_q && alu_carryout;
    end
  end

  // Completed-response counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_done_q <= '0;
    end else if ((state_q == StResp) && resp_ready) begin
      ops_done_q <= ops_done_q + CNT_W'(1);
    end
  end

  // Output drive.
  always_comb begin
    resp_valid    = (state_q == StResp);
    resp_id       = resp_id_q;
    resp_out      = resp_out_q;
    resp_overflow = resp_ovf_q;
    resp_zero     = resp_zero_q;
    resp_carryout = resp_cout_q;
    resp_illegal  = resp_ill_q;
    alu_op        = alu_op_q;
    alu_in0       = alu_in0_q;
    alu_in1       = alu_in1_q;
    ops_done      = ops_done_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter with a behavioural ALU model.
module tb_alu_arbiter;

  logic        clk, rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [10:0] req0_op, req1_op;
  logic [31:0] req0_in0, req0_in1, req1_in0, req1_in1;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_out;
  logic        resp_overflow, resp_zero, resp_carryout, resp_illegal;
  logic [10:0] alu_op;
  logic [31:0] alu_in0, alu_in1, alu_out;
  logic        alu_overflow, alu_zero, alu_carryout;
  logic [3:0]  ops_done;

  typedef struct packed {
    logic        id;
    logic [31:0] out;
    logic        ovf, zero, cout, ill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_cnt = 0;
  int   cyc = 0;
  int   grant_id[$];
  int   grant_cyc[$];

  alu_arbiter #(.OP_W(11), .DATA_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_in0(req0_in0), .req0_in1(req0_in1),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_in0(req1_in0), .req1_in1(req1_in1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_out(resp_out), .resp_overflow(resp_overflow), .resp_zero(resp_zero),
    .resp_carryout(resp_carryout), .resp_illegal(resp_illegal),
    .alu_op(alu_op), .alu_in0(alu_in0), .alu_in1(alu_in1),
    .alu_out(alu_out), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .alu_carryout(alu_carryout), .ops_done(ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Behavioural subset of the MIPS ALU.
  logic [32:0] t;
  always_comb begin
    t = '0;
    alu_overflow = 1'b0;
    case (alu_op)
      11'h020: begin
        t = {1'b0, alu_in0} + {1'b0, alu_in1};
        alu_overflow = (alu_in0[31] == alu_in1[31]) && (t[31] != alu_in0[31]);
      end
      11'h021: t = {1'b0, alu_in0} + {1'b0, alu_in1};
      11'h022: begin
        t = {1'b0, alu_in0} - {1'b0, alu_in1};
        alu_overflow = (alu_in0[31] != alu_in1[31]) && (t[31] != alu_in0[31]);
      end
      11'h023: t = {1'b0, alu_in0} - {1'b0, alu_in1};
      11'h024: t = {1'b0, alu_in0 & alu_in1};
      11'h025: t = {1'b0, alu_in0 | alu_in1};
      11'h026: t = {1'b0, alu_in0 ^ alu_in1};
      11'h027: t = {1'b0, ~(alu_in0 | alu_in1)};
      default: t = '0;
    endcase
    alu_out      = t[31:0];
    alu_carryout = t[32];
    alu_zero     = (t[31:0] == 32'd0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic id, input logic [31:0] out,
                              input logic ovf, input logic zero, input logic cout,
                              input logic ill);
    exp_t e;
    e.id = id; e.out = out; e.ovf = ovf; e.zero = zero; e.cout = cout; e.ill = ill;
    return e;
  endfunction

  // Monitor: pops one expectation per response handshake.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: got id=%0d out=0x%0h expected none", resp_id, resp_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp", 64'({resp_id, resp_out, resp_overflow, resp_zero, resp_carryout,
                         resp_illegal}), 64'(e));
      end
      chk("ops_done_at_resp", 64'(ops_done), 64'(exp_cnt % 16));
      exp_cnt++;
    end
  end

  // Present one request and wait (bounded) for its accept; returns the accept cycle.
  task automatic issue(input bit idx, input logic [10:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    if (idx == 1'b0) begin
      req0_valid = 1'b1; req0_op = op; req0_in0 = a; req0_in1 = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_in0 = a; req1_in1 = b;
    end
    #1;
    for (int i = 0; i < 40 && !got; i++) begin
      if ((idx == 1'b0 && req0_ready) || (idx == 1'b1 && req1_ready)) begin
        got = 1'b1;
        acc = cyc;
      end
      @(posedge clk);
      #1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got no ready expected ready for req%0d", idx);
    end
    if (idx == 1'b0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  // With both valids already driven, log n grants then drop both valids.
  task automatic run_both(input int n);
    grant_id.delete();
    grant_cyc.delete();
    #1;
    for (int i = 0; i < 100; i++) begin
      if (req0_ready && req1_ready) chk("one_ready", 64'd1, 64'd0);
      if (req0_ready) begin grant_id.push_back(0); grant_cyc.push_back(cyc); end
      if (req1_ready) begin grant_id.push_back(1); grant_cyc.push_back(cyc); end
      @(posedge clk);
      #1;
      if (grant_id.size() >= n) break;
    end
    chk("grant_count", 64'(grant_id.size()), 64'(n));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, r;
    rst = 1'b1;
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 11'h020; req0_in0 = 32'd0; req0_in1 = 32'd0;
    req1_valid = 1'b1; req1_op = 11'h020; req1_in0 = 32'd0; req1_in1 = 32'd0;
    #3;
    chk("rst_req0_ready", 64'(req0_ready), 64'd0);
    chk("rst_req1_ready", 64'(req1_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_fields", 64'({resp_id, resp_out, resp_overflow, resp_zero, resp_carryout,
                                resp_illegal}), 64'd0);
    chk("rst_alu_bus", 64'({alu_op, alu_in0, alu_in1}), 64'd0);
    chk("rst_ops_done", 64'(ops_done), 64'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single add with signed overflow.
    sb.push_back(mk(1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0));
    issue(1'b0, 11'h020, 32'h7FFF_FFFF, 32'd1, acc);
    @(negedge clk);
    chk("lat_exec_resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    chk("lat_resp_valid", 64'(resp_valid), 64'd1);
    @(negedge clk);
    chk("add_ops_done", 64'(ops_done), 64'd1);
    chk("add_resp_valid_falls", 64'(resp_valid), 64'd0);

    // Illegal opcode from req1: zeroed response, ALU bus keeps the add.
    sb.push_back(mk(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    issue(1'b1, 11'h001, 32'hDEAD, 32'hBEEF, acc);
    repeat (3) @(negedge clk);
    chk("illegal_alu_op", 64'(alu_op), 64'h020);
    chk("illegal_alu_in0", 64'(alu_in0), 64'h7FFF_FFFF);
    chk("illegal_alu_in1", 64'(alu_in1), 64'd1);
    chk("illegal_ops_done", 64'(ops_done), 64'd2);

    // Contention: last winner was req1, so order is 0,1,0,1.
    sb.push_back(mk(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0));
    sb.push_back(mk(1'b1, 32'h0000_00F0, 1'b0, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0));
    sb.push_back(mk(1'b1, 32'h0000_00F0, 1'b0, 1'b0, 1'b0, 1'b0));
    req0_op = 11'h023; req0_in0 = 32'd0;      req0_in1 = 32'd1;      req0_valid = 1'b1;
    req1_op = 11'h024; req1_in0 = 32'hF0F0;   req1_in1 = 32'h0FF0;   req1_valid = 1'b1;
    run_both(4);
    if (grant_id.size() >= 4) begin
      chk("grant_order", 64'({grant_id[0][1:0], grant_id[1][1:0], grant_id[2][1:0],
                              grant_id[3][1:0]}), 64'b00_01_00_01);
      chk("req0_period", 64'(grant_cyc[2] - grant_cyc[0]), 64'd6);
      chk("req1_period", 64'(grant_cyc[3] - grant_cyc[1]), 64'd6);
    end
    repeat (4) @(negedge clk);

    // Backpressure: response held 5 cycles while req1 waits.
    resp_ready = 1'b0;
    sb.push_back(mk(1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(1'b1, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    issue(1'b0, 11'h025, 32'h0000_00FF, 32'h0000_FF00, acc);
    req1_op = 11'h026; req1_in0 = 32'h1234; req1_in1 = 32'h1234; req1_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_resp_valid", 64'(resp_valid), 64'd1);
      chk("bp_resp_hold", 64'({resp_id, resp_out, resp_overflow, resp_zero, resp_carryout,
                               resp_illegal}), 64'(mk(1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0,
                                                       1'b0)));
      chk("bp_req1_ready", 64'(req1_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    r = cyc;
    issue(1'b1, 11'h026, 32'h1234, 32'h1234, acc);
    chk("bp_accept_cycle", 64'(acc), 64'(r + 1));
    repeat (3) @(negedge clk);
    chk("bp_ops_done", 64'(ops_done), 64'd8);

    // Reset during EXEC: operation discarded, everything back to reset values.
    issue(1'b0, 11'h020, 32'd5, 32'd6, acc);
    #2;
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_alu_bus", 64'({alu_op, alu_in0, alu_in1}), 64'd0);
    chk("mid_rst_resp_fields", 64'({resp_id, resp_out, resp_overflow, resp_zero,
                                    resp_carryout, resp_illegal}), 64'd0);
    chk("mid_rst_ops_done", 64'(ops_done), 64'd0);
    chk("mid_rst_readys", 64'({req0_ready, req1_ready}), 64'd0);
    exp_cnt = 0;
    @(posedge clk);
    #1;
    chk("held_rst_resp_valid", 64'(resp_valid), 64'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(mk(1'b0, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(1'b1, 32'h0000_00F0, 1'b0, 1'b0, 1'b0, 1'b0));
    req0_op = 11'h020; req0_in0 = 32'd1;    req0_in1 = 32'd2;    req0_valid = 1'b1;
    req1_op = 11'h024; req1_in0 = 32'hF0F0; req1_in1 = 32'h0FF0; req1_valid = 1'b1;
    run_both(2);
    if (grant_id.size() >= 2) begin
      chk("post_rst_first_grant", 64'(grant_id[0]), 64'd0);
    end
    repeat (4) @(negedge clk);
    chk("post_rst_ops_done", 64'(ops_done), 64'd2);

    // Counter wrap with CNT_W=4: ops 3..17 after reset.
    for (int k = 3; k <= 17; k++) begin
      sb.push_back(mk(1'b0, 32'(k + 1), 1'b0, 1'b0, 1'b0, 1'b0));
      issue(1'b0, 11'h021, 32'(k), 32'd1, acc);
      repeat (3) @(negedge clk);
      if (k >= 15) chk("wrap_ops_done", 64'(ops_done), 64'(k % 16));
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
